// File: rtl/read_return_arbiter_if.sv
// Shared return type and the bus bundle between the return sources, the
// arbiter and the scheduler's data_return input.
package read_return_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  receive_id;
    logic [15:0] payload;
  } read_return_t;
endpackage

// Handshake contract: a source presents src_return[i] with .valid=1 and the
// entry is taken on the rising edge if src_ready[i]=1 in that cycle; if
// src_ready[i]=0 the entry is dropped and overflow_err[i] latches. The
// data_return side has no back-pressure: .valid=1 means one return, consumed
// in exactly that cycle.
interface read_return_if #(
  parameter int NUM_SRC = 4
) ();
  import read_return_pkg::*;

  read_return_t [NUM_SRC-1:0] src_return;
  logic [NUM_SRC-1:0]         src_ready;
  logic                       halt;
  read_return_t               data_return;
  logic                       busy;
  logic [NUM_SRC-1:0]         overflow_err;
  // Round-robin pointer, exposed for observation only.
  logic [$clog2(NUM_SRC)-1:0] arb_ptr;

  modport slave (
    input  src_return, halt,
    output src_ready, data_return, busy, overflow_err, arb_ptr
  );

  modport master (
    output src_return, halt,
    input  src_ready, data_return, busy, overflow_err, arb_ptr
  );
endinterface

// File: rtl/read_return_arbiter.sv
// Per-source return FIFOs drained round-robin, one entry per cycle, into a
// registered data_return stream. halt freezes draining; filling continues.
module read_return_arbiter
  import read_return_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  read_return_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NUM_SRC);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW:0]   NSRC     = (SW + 1)'(NUM_SRC);
  localparam logic [SW-1:0] LAST_SRC = SW'(NUM_SRC - 1);

  read_return_t       mem    [NUM_SRC][DEPTH];
  logic [PW-1:0]      rd_ptr [NUM_SRC];
  logic [PW-1:0]      wr_ptr [NUM_SRC];
  logic [CW-1:0]      count  [NUM_SRC];
  logic [SW-1:0]      rr_ptr;
  read_return_t       data_q;
  logic [NUM_SRC-1:0] ovf_q;

  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_valid;
  logic [SW-1:0]      grant;
  logic [SW:0]        scan_sum;
  logic [SW:0]        scan_idx;

  // Ready/occupancy come only from registered counts, so a same-cycle pop
  // never frees a slot for a same-cycle push.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i]    = (count[i] < FULL_CNT);
      nonempty[i] = (count[i] != '0);
      push[i]     = bus.src_return[i].valid & ready[i];
    end
  end

  // First non-empty FIFO at or after rr_ptr wins; entries pushed this cycle
  // are not yet visible, which gives the no-bypass behaviour.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_sum = {1'b0, rr_ptr} + (SW + 1)'(k);
      scan_idx = (scan_sum >= NSRC) ? (scan_sum - NSRC) : scan_sum;
      if (!grant_valid && nonempty[SW'(scan_idx)]) begin
        grant_valid = 1'b1;
        grant       = SW'(scan_idx);
      end
    end
  end

  // At most one pop per cycle, suppressed entirely while halted.
  always_comb begin
    pop = '0;
    if (grant_valid && !bus.halt) pop[grant] = 1'b1;
  end

  // Entry storage; contents are don't-care until a count covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.src_return[i];
    end
  end

  // FIFO pointers, counts and sticky overflow flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
        if (bus.src_return[i].valid && !ready[i]) ovf_q[i] <= 1'b1;
      end
    end
  end

  // Registered output and round-robin pointer advance on each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      rr_ptr <= '0;
    end else if (grant_valid && !bus.halt) begin
      data_q <= mem[grant][rd_ptr[grant]];
      rr_ptr <= (grant == LAST_SRC) ? '0 : grant + 1'b1;
    end else begin
      data_q <= '0;
    end
  end

  assign bus.src_ready    = ready;
  assign bus.data_return  = data_q;
  assign bus.busy         = (|nonempty) | data_q.valid;
  assign bus.overflow_err = ovf_q;
  assign bus.arb_ptr      = rr_ptr;
endmodule

// File: tb/tb_read_return_arbiter.sv
// Bench for read_return_arbiter: directed tables, hand sequences for reset
// corners, and randomized traffic against a queue-based reference model.
module tb_read_return_arbiter;
  import read_return_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  read_return_if #(.NUM_SRC(NUM_SRC)) bus ();

  read_return_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       halt;
    logic [3:0] vmask;
    logic [5:0] base;
    logic       exp_valid;
    logic [5:0] exp_id;
    logic [3:0] exp_ready;
    logic       exp_busy;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (cycle-level, queue based).
  read_return_t mq [NUM_SRC][$];
  int           m_rr;
  read_return_t m_out;
  logic [3:0]   m_ovf;

  function automatic read_return_t mk_ret(input logic [5:0] id);
    read_return_t r;
    r.valid      = 1'b1;
    r.receive_id = id;
    r.payload    = {id, 10'h155};
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    m_rr  = 0;
    m_out = '0;
    m_ovf = '0;
  endtask

  // Enter and leave at a falling edge; inputs idle.
  task automatic do_reset();
    bus.halt = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) bus.src_return[i] = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic drive_mask(input logic h, input logic [3:0] vmask, input logic [5:0] base);
    bus.halt = h;
    for (int i = 0; i < NUM_SRC; i++)
      bus.src_return[i] = vmask[i] ? mk_ret(base + 6'(i)) : '0;
  endtask

  task automatic add(input logic h, input logic [3:0] vm, input logic [5:0] base,
                     input logic ev, input logic [5:0] eid, input logic [3:0] erdy,
                     input logic eb, input logic [3:0] eovf);
    vec_t v;
    v.halt = h; v.vmask = vm; v.base = base; v.exp_valid = ev; v.exp_id = eid;
    v.exp_ready = erdy; v.exp_busy = eb; v.exp_ovf = eovf;
    tbl.push_back(v);
  endtask

  // Each record: inputs for one cycle, outputs expected after that edge.
  task automatic run_table(input string nm);
    read_return_t exp_d;
    for (int k = 0; k < tbl.size(); k++) begin
      drive_mask(tbl[k].halt, tbl[k].vmask, tbl[k].base);
      @(negedge clk);
      exp_d = tbl[k].exp_valid ? mk_ret(tbl[k].exp_id) : '0;
      check($sformatf("%s[%0d].data", nm, k), 64'(bus.data_return), 64'(exp_d));
      check($sformatf("%s[%0d].ready", nm, k), 64'(bus.src_ready), 64'(tbl[k].exp_ready));
      check($sformatf("%s[%0d].busy", nm, k), 64'(bus.busy), 64'(tbl[k].exp_busy));
      check($sformatf("%s[%0d].ovf", nm, k), 64'(bus.overflow_err), 64'(tbl[k].exp_ovf));
    end
    drive_mask(1'b0, 4'h0, 6'd0);
    tbl.delete();
  endtask

  // One arbitration cycle of the reference model using the current inputs.
  task automatic model_step();
    int   g;
    logic rdy [NUM_SRC];
    g = -1;
    for (int i = 0; i < NUM_SRC; i++) rdy[i] = (mq[i].size() < DEPTH);
    if (!bus.halt) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        int idx;
        idx = (m_rr + k) % NUM_SRC;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
    end
    if (g >= 0) begin
      m_out = mq[g].pop_front();
      m_rr  = (g + 1) % NUM_SRC;
    end else begin
      m_out = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_return[i].valid) begin
        if (rdy[i]) mq[i].push_back(bus.src_return[i]);
        else        m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic run_random(input int cycles, input int push_pct, input int halt_pct);
    logic [3:0] exp_rdy;
    logic       exp_busy;
    read_return_t r;
    for (int c = 0; c < cycles; c++) begin
      exp_rdy  = '0;
      exp_busy = m_out.valid;
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_rdy[i] = (mq[i].size() < DEPTH);
        if (mq[i].size() > 0) exp_busy = 1'b1;
      end
      check("rnd.data", 64'(bus.data_return), 64'(m_out));
      check("rnd.ready", 64'(bus.src_ready), 64'(exp_rdy));
      check("rnd.busy", 64'(bus.busy), 64'(exp_busy));
      check("rnd.ovf", 64'(bus.overflow_err), 64'(m_ovf));
      bus.halt = ($urandom_range(0, 99) < halt_pct);
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 99) < push_pct) begin
          r.valid      = 1'b1;
          r.receive_id = 6'($urandom_range(0, 63));
          r.payload    = 16'($urandom);
          bus.src_return[i] = r;
        end else begin
          bus.src_return[i] = '0;
        end
      end
      model_step();
      @(negedge clk);
    end
    drive_mask(1'b0, 4'h0, 6'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    drive_mask(1'b0, 4'h0, 6'd0);
    model_clear();
    @(negedge clk);

    // Reset held with pushes on every source: nothing enters.
    rst = 1'b0;
    drive_mask(1'b0, 4'hF, 6'd1);
    @(negedge clk);
    check("rst.data", 64'(bus.data_return), 64'd0);
    check("rst.ready", 64'(bus.src_ready), 64'hF);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.ovf", 64'(bus.overflow_err), 64'd0);
    // First cycle after release: push id 5 on source 2.
    rst = 1'b1;
    bus.halt = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) bus.src_return[i] = '0;
    bus.src_return[2] = mk_ret(6'd5);
    @(negedge clk);
    drive_mask(1'b0, 4'h0, 6'd0);
    check("rel.e1.data", 64'(bus.data_return), 64'd0);
    check("rel.e1.busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("rel.e2.data", 64'(bus.data_return), 64'(mk_ret(6'd5)));
    @(negedge clk);
    check("rel.e3.data", 64'(bus.data_return), 64'd0);
    check("rel.e3.busy", 64'(bus.busy), 64'd0);

    // Round-robin across all sources, two waves, no bubbles.
    do_reset();
    add(0, 4'hF, 6'd10, 0, 6'd0,  4'hF, 1, 4'h0);
    add(0, 4'hF, 6'd20, 1, 6'd10, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd11, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd12, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd13, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd20, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd21, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd22, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  1, 6'd23, 4'hF, 1, 4'h0);
    add(0, 4'h0, 6'd0,  0, 6'd0,  4'hF, 0, 4'h0);
    run_table("rr");

    // Back-pressure on source 1 under halt, then a plain halt window on 0.
    do_reset();
    add(1, 4'h2, 6'd40, 0, 6'd0,  4'hF, 1, 4'h0);
    add(1, 4'h2, 6'd50, 0, 6'd0,  4'hF, 1, 4'h0);
    add(1, 4'h2, 6'd60, 0, 6'd0,  4'hF, 1, 4'h0);
    add(1, 4'h2, 6'd70, 0, 6'd0,  4'hD, 1, 4'h0);
    add(1, 4'h2, 6'd80, 0, 6'd0,  4'hD, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd41, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd51, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd61, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd71, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  0, 6'd0,  4'hF, 0, 4'h2);
    add(1, 4'h1, 6'd90, 0, 6'd0,  4'hF, 1, 4'h2);
    add(1, 4'h1, 6'd91, 0, 6'd0,  4'hF, 1, 4'h2);
    add(1, 4'h1, 6'd92, 0, 6'd0,  4'hF, 1, 4'h2);
    add(1, 4'h0, 6'd0,  0, 6'd0,  4'hF, 1, 4'h2);
    add(1, 4'h0, 6'd0,  0, 6'd0,  4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd90, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd91, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  1, 6'd92, 4'hF, 1, 4'h2);
    add(0, 4'h0, 6'd0,  0, 6'd0,  4'hF, 0, 4'h2);
    run_table("bp");

    // Asynchronous reset between edges with six entries queued.
    do_reset();
    repeat (3) begin
      drive_mask(1'b1, 4'h3, 6'd30);
      @(negedge clk);
    end
    drive_mask(1'b0, 4'h0, 6'd0);
    @(posedge clk);
    #2;
    check("arst.pre.data", 64'(bus.data_return), 64'(mk_ret(6'd30)));
    check("arst.pre.busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    check("arst.data", 64'(bus.data_return), 64'd0);
    check("arst.busy", 64'(bus.busy), 64'd0);
    check("arst.ready", 64'(bus.src_ready), 64'hF);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("arst.post.data", 64'(bus.data_return), 64'd0);
      check("arst.post.busy", 64'(bus.busy), 64'd0);
    end

    // Randomized traffic against the queue model: light, then heavy.
    do_reset();
    run_random(300, 20, 10);
    do_reset();
    run_random(400, 60, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/read_return_arbiter.md
# read_return_arbiter

Merges read returns from NUM_SRC independent memory/data ports into the single `read_return_t` stream that feeds the thread scheduler's `data_return` input, which accepts at most one return per cycle and has no back-pressure. Each source gets a DEPTH-entry FIFO with a ready signal. A round-robin grant drains one entry per cycle into a registered output. A halt input freezes draining while FIFOs keep filling.

## Interface
- NUM_SRC, 4, number of return sources (2..8)
- DEPTH, 4, per-source FIFO entries (power of two, 2..16)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- halt  in  1  1 = issue no grants this cycle
- src_return[NUM_SRC]  in  read_return_t each  per-source return; push when `.valid`=1
- src_ready[NUM_SRC]  out  1 each  1 = FIFO i has a free entry this cycle
- data_return  out  read_return_t  registered arbitrated return to scheduler
- busy  out  1  any FIFO non-empty or data_return.valid=1
- overflow_err[NUM_SRC]  out  1 each  sticky: push arrived while src_ready[i]=0

## Operation
- Per-source FIFO i: circular buffer, rd/wr pointers log2(DEPTH) bits wrapping modulo DEPTH, count log2(DEPTH)+1 bits.
- src_ready[i] = (count_i < DEPTH), combinational from the registered count. It does not depend on a same-cycle pop.
- Push: src_return[i].valid=1 and src_ready[i]=1 writes the whole struct unmodified (receive_id and payload) at the wr pointer.
- Push with src_ready[i]=0: entry dropped, FIFO unchanged, overflow_err[i] set to 1. It stays 1 until reset.
- Arbitration each cycle, when halt=0:
  - Candidates are FIFOs with count>0 at the cycle start.
  - Grant the first candidate scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - Pop the granted FIFO, register its head into data_return, set rr_ptr ← grant+1 modulo NUM_SRC.
- No candidate, or halt=1: data_return ← all-zero (valid=0); rr_ptr unchanged.
- Simultaneous push and pop on the same FIFO: both occur and count is unchanged.
  - Empty FIFO: the pushed entry is not eligible until the next cycle (no bypass).
  - Full FIFO: the push is refused (src_ready=0) even though a pop happens.
- Ordering: strict FIFO within a source. Across sources, fair round-robin; no source waits more than NUM_SRC−1 grants while non-empty.
- busy = OR(count_i>0) | data_return.valid.

## Timing
- Reset (rst=0, asynchronous):
  - all counts and pointers 0; rr_ptr=0
  - data_return all-zero; overflow_err all 0
  - src_ready all 1 (derived from count=0); busy 0
- A reset mid-operation discards all FIFO contents immediately. The first push is accepted in the first cycle after rst deasserts.
- Latency: push sampled at edge E into an empty FIFO with no contention and halt=0 → data_return.valid=1 after edge E+1. Minimum latency is 2 edges.
- Throughput: one return per cycle total. A single source with a steady stream sustains one per cycle.
- halt is sampled per cycle. halt=1 at edge E gives data_return.valid=0 after E, and grants resume on the first edge with halt=0.
- data_return is valid for exactly one cycle per grant; the downstream never stalls.

## Test plan
- Reset: hold rst=0 with pushes on all sources → data_return.valid=0, src_ready=4'b1111, busy=0, overflow_err=0. Release rst; a push on src 2 with receive_id=5 → data_return.valid=1 with receive_id=5 two edges later.
- Round-robin: push ids 10,11,12,13 on sources 0–3 in the same cycle, then again next cycle with 20–23 → output order 10,11,12,13,20,21,22,23 on consecutive cycles, no bubbles.
- Back-pressure: halt=1, push 4 entries into src 1 → src_ready[1]=0 after the 4th. A 5th push sets overflow_err[1]=1 and is dropped. Release halt → exactly 4 outputs, in order, src_ready[1] returns to 1.
- Fairness: src 0 pushes every cycle, src 3 pushes once → src 3's entry appears within 2 grants of becoming eligible; src 0 order is preserved.
- Halt: 3 entries queued on src 0, halt=1 for 5 cycles → no valid outputs, busy=1. Deassert halt → 3 outputs on the next 3 cycles.
- Async reset mid-stream: assert rst=0 between clock edges with 6 entries queued → outputs and counts clear without waiting for a clock edge. After release there are no stale returns and busy=0.
